// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern/length and overlapping or non-overlapping matching.
// Optional saturating match counter is built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int                 MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1101,
  parameter int                 DEF_LEN = 4,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w,
  input  logic                         w_valid,
  input  logic                         ovl_en,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pat,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
`ifdef SEQ_DET_MATCH_CNT_EN
  output logic [CNT_W-1:0]             match_cnt,
`endif
  output logic                         z
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamp;
  logic               match;

  // Everything here looks at the bit arriving on this edge, so a match is
  // decided from the post-shift history and post-increment fill.
  always_comb begin
    hist_nxt = {history[MAX_LEN-2:0], w};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    fill_inc  = (fill >= len) ? len : fill + 1'b1;
    match     = (len != '0) && (fill_inc == len) &&
                (((hist_nxt ^ pat) & mask) == '0);
    len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
      pat     <= DEF_PAT;
      len     <= LEN_W'(DEF_LEN);
      z       <= 1'b0;
    end else if (cfg_load) begin
      history <= '0;
      fill    <= '0;
      pat     <= cfg_pat;
      len     <= len_clamp;
      z       <= 1'b0;
    end else if (w_valid) begin
      history <= hist_nxt;
      // Non-overlapping mode restarts from empty so no matched bit is reused.
      fill    <= (match && !ovl_en) ? '0 : fill_inc;
      z       <= match;
    end else begin
      z       <= 1'b0;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      match_cnt <= '0;
    end else if (w_valid && match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule
